// File: rtl/param_load_counter.sv
// Loadable up/down counter with configurable width, step, saturation and
// auto-reload, used to count the remaining additions in the repeated-addition
// multiplier. Status flags and one-cycle pulses feed the multiplier control FSM.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   load       in   load din into the count and the reload register
//   din        in   [WIDTH] load value
//   en         in   count enable
//   up         in   direction, 1 = up, 0 = down (sampled with en)
//   dout       out  [WIDTH] current count (registered)
//   zero       out  dout == 0
//   at_max     out  dout == all ones
//   tc_pulse   out  registered pulse: a count step landed on the terminal value
//   wrap_pulse out  registered pulse: a step wrapped or auto-reloaded
module param_load_counter #(
    parameter int WIDTH       = 16,
    parameter int STEP        = 1,
    parameter bit SATURATE    = 1'b1,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] dout,
    output logic             zero,
    output logic             at_max,
    output logic             tc_pulse,
    output logic             wrap_pulse
);

    localparam logic [WIDTH-1:0] MAX    = '1;
    localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;
    logic             wrap_q, wrap_d;

    // One extra bit: its top bit is the carry (up) or borrow (down)
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] term;

    assign sum  = {1'b0, cnt_q} + STEP_X;
    assign diff = {1'b0, cnt_q} - STEP_X;
    assign term = up ? MAX : '0;

    always_comb begin
        cnt_d    = cnt_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        wrap_d   = 1'b0;
        if (load) begin
            cnt_d    = din;
            reload_d = din;
        end else if (en) begin
            if (up) begin
                if (!sum[WIDTH]) begin
                    cnt_d = sum[WIDTH-1:0];
                end else if (SATURATE) begin
                    cnt_d = MAX;
                end else begin
                    cnt_d  = sum[WIDTH-1:0];
                    wrap_d = 1'b1;
                end
            end else begin
                if (!diff[WIDTH]) begin
                    cnt_d = diff[WIDTH-1:0];
                end else if (AUTO_RELOAD) begin
                    // Reload takes precedence over both clamp and wrap
                    cnt_d  = reload_q;
                    wrap_d = 1'b1;
                end else if (SATURATE) begin
                    cnt_d = '0;
                end else begin
                    cnt_d  = diff[WIDTH-1:0];
                    wrap_d = 1'b1;
                end
            end
            // Only an arrival on the terminal pulses; holding there does not
            tc_d = (cnt_q != term) && (cnt_d == term);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
            wrap_q   <= wrap_d;
        end
    end

    assign dout       = cnt_q;
    assign zero       = (cnt_q == '0);
    assign at_max     = (cnt_q == MAX);
    assign tc_pulse   = tc_q;
    assign wrap_pulse = wrap_q;

endmodule
